pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enables and bubbles of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It merges three event sources: load-use hazards, taken branches resolved in ID, and a data memory that can take multiple cycles.
- It sits beside the forwarding unit and replaces the ad-hoc PCSrcD_Control and flush wiring.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_wait_timer.sv | 20 ++
 rtl/pipe_stall_ctrl.sv | 86 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and stage-control bundle for pipe_stall_ctrl
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, ERROR} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_bubble;
    } ctrl_t;
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_ERR    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: saturating memory-wait cycle counter; start loads 1, inc counts, otherwise clears
module pipe_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inc,
    output logic expire
);
    localparam int TW = $clog2(LIMIT + 1);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= start ? TW'(1) : inc ? ((cnt == TW'(LIMIT)) ? cnt : cnt + 1'b1) : '0;
    end
    assign expire = (cnt == TW'(LIMIT - 1));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage pipeline (Mealy outputs from state + inputs).
// Define PIPE_STALL_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_STALL_CTRL_PERF_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              uses_rs2_id,
    input  logic              branch_taken_id,
    input  logic              mem_req_mem,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_mem_en,
    output logic              mem_wb_bubble,
    output logic              mem_timeout,
    output logic [1:0]        state_o
`ifdef PIPE_STALL_CTRL_PERF_EN
    , output logic [CNT_W-1:0] lu_stall_cnt
    , output logic [CNT_W-1:0] mw_stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    state_t state, nxt;
    ctrl_t  ctrl;
    logic   lu, mw, start, inc, expire;
    assign lu = memread_ex && rd_ex != REG_AW'(REG_ZERO)
                && (rd_ex == rs1_id || (uses_rs2_id && rd_ex == rs2_id));
    assign mw = mem_req_mem && !mem_ready;
    // priority mw > lu > branch; lu is masked in LOAD_STALL because EX holds the bubble
    always_comb begin
        ctrl  = CTRL_RESET;
        nxt   = RUN;
        start = 1'b0;
        inc   = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (state == ERROR) begin
            ctrl = CTRL_ERR;
            nxt  = ERROR;
        end else if (mw) begin
            ctrl  = CTRL_FREEZE;
            inc   = (state == MEM_WAIT);
            start = (state != MEM_WAIT);
            nxt   = (inc && expire) ? ERROR : MEM_WAIT;
        end else if (lu && state != LOAD_STALL) begin
            ctrl = CTRL_STALL;
            nxt  = LOAD_STALL;
        end else begin
            ctrl = branch_taken_id ? CTRL_FLUSH : CTRL_RUN;
        end
    end
    always_ff @(posedge clk) state <= nxt;
    pipe_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .start(start), .inc(inc), .expire(expire)
    );
    assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble} = ctrl;
    assign mem_timeout = !rst && state == ERROR;
    assign state_o     = state;
`ifdef PIPE_STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            mw_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            lu_stall_cnt <= lu_stall_cnt + CNT_W'(ctrl == CTRL_STALL && lu_stall_cnt != '1);
            mw_stall_cnt <= mw_stall_cnt + CNT_W'(ctrl == CTRL_FREEZE && mw_stall_cnt != '1);
            flush_cnt    <= flush_cnt + CNT_W'(ctrl == CTRL_FLUSH && flush_cnt != '1);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl with MEM_TIMEOUT=4
module tb_pipe_stall_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic memread_ex = 1'b0, uses_rs2_id = 1'b0, branch_taken_id = 1'b0;
    logic mem_req_mem = 1'b0, mem_ready = 1'b0;
    logic [4:0] rd_ex = '0, rs1_id = '0, rs2_id = '0;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, mem_timeout;
    logic [1:0] state_o;
`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [31:0] lu_stall_cnt, mw_stall_cnt, flush_cnt;
`endif
    int total = 0, bad = 0;
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
    localparam logic [6:0] P_RUN = 7'b1101010, P_FRZ = 7'b0000001, P_RST = 7'b0010101;
    localparam logic [6:0] P_STL = 7'b0001110, P_FL = 7'b1111010, P_ERR = 7'b0000000;
    wire [6:0] ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble};

    pipe_stall_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_id(rs1_id),
        .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id), .branch_taken_id(branch_taken_id),
        .mem_req_mem(mem_req_mem), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
        .state_o(state_o)
`ifdef PIPE_STALL_CTRL_PERF_EN
        , .lu_stall_cnt(lu_stall_cnt), .mw_stall_cnt(mw_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // apply inputs just after a falling edge, then let combinational outputs settle
    task automatic drive(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u2, input logic br, input logic rq,
                         input logic rdy);
        @(negedge clk);
        rst = r; memread_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
        uses_rs2_id = u2; branch_taken_id = br; mem_req_mem = rq; mem_ready = rdy;
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] ectl, input logic [1:0] est);
        chk({tag, " ctl"}, 32'(ctl), 32'(ectl));
        chk({tag, " st"}, 32'(state_o), 32'(est));
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset ctl", 32'(ctl), 32'(P_RST));
        chk("reset mto", 32'(mem_timeout), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle", P_RUN, 0);
        chk("idle mto", 32'(mem_timeout), 0);
        // load-use on rs1
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0); step("lu rs1", P_STL, 0);
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0); step("lu masked", P_RUN, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("lu back", P_RUN, 0);
        // x0 and rs2 masking, then rs2 hazard
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0); step("x0", P_RUN, 0);
        drive(0, 1, 7, 1, 7, 0, 0, 0, 0); step("rs2 unused", P_RUN, 0);
        drive(0, 1, 7, 1, 7, 1, 0, 0, 0); step("rs2 used", P_STL, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("rs2 after", P_RUN, 1);
        // branch flush, branch under stall, branch honoured in LOAD_STALL
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("br", P_FL, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("br after", P_RUN, 0);
        drive(0, 1, 3, 3, 0, 0, 1, 0, 0); step("br+lu", P_STL, 0);
        drive(0, 1, 3, 3, 0, 0, 1, 0, 0); step("br in ls", P_FL, 1);
        // memory wait of MEM_TIMEOUT-1 cycles, released with a new load-use
        drive(0, 1, 3, 3, 0, 0, 1, 1, 0); step("mw1 beats lu/br", P_FRZ, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mw2", P_FRZ, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mw3", P_FRZ, 2);
        drive(0, 1, 4, 4, 0, 0, 0, 1, 1); step("mw rdy lu", P_STL, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mw ls", P_RUN, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mw run", P_RUN, 0);
        chk("mw mto", 32'(mem_timeout), 0);
        // plain wait released by ready, and LOAD_STALL into MEM_WAIT
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mwb1", P_FRZ, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step("mwb rdy", P_RUN, 2);
        drive(0, 1, 6, 6, 0, 0, 0, 0, 0); step("ls pre", P_STL, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("ls mw", P_FRZ, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step("ls mw rdy", P_RUN, 2);
        // timeout: exactly MEM_TIMEOUT frozen cycles trips ERROR
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("to1", P_FRZ, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("to2", P_FRZ, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("to3", P_FRZ, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("to4", P_FRZ, 2);
        chk("to4 mto", 32'(mem_timeout), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("err", P_ERR, 3);
        chk("err mto", 32'(mem_timeout), 1);
        drive(0, 1, 2, 2, 0, 0, 1, 0, 1); step("err hold", P_ERR, 3);
        chk("err hold mto", 32'(mem_timeout), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err rst ctl", 32'(ctl), 32'(P_RST));
        chk("err rst mto", 32'(mem_timeout), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("post rst", P_RUN, 0);
        chk("post rst mto", 32'(mem_timeout), 0);
        // reset in MEM_WAIT
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step("rmw1", P_FRZ, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0); chk("rmw rst st", 32'(state_o), 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("rmw after", P_RUN, 0);
`ifdef PIPE_STALL_CTRL_PERF_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf lu", lu_stall_cnt, 2);
        chk("perf mw", mw_stall_cnt, 3);
        chk("perf fl", flush_cnt, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf lu rst", lu_stall_cnt, 0);
        chk("perf mw rst", mw_stall_cnt, 0);
        chk("perf fl rst", flush_cnt, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
